// File: rtl/spatz_l1d_pkg.sv
// Shared types for the Spatz L1D maintenance controller: op encoding,
// walk FSM states and small decode helpers.
package spatz_l1d_pkg;

  // Cache maintenance op as delivered by the cluster peripheral.
  typedef enum logic [1:0] {
    INSN_NOP       = 2'b00,
    INSN_FLUSH     = 2'b01,
    INSN_INV       = 2'b10,
    INSN_FLUSH_INV = 2'b11
  } insn_e;

  // States of the line walk.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_TAG   = 3'd1,
    ST_WAIT_TAG = 3'd2,
    ST_WB_REQ   = 3'd3,
    ST_WB_WAIT  = 3'd4,
    ST_WR_TAG   = 3'd5,
    ST_NEXT     = 3'd6,
    ST_DONE     = 3'd7
  } state_e;

  // Width of the scratchpad-way count input.
  localparam int unsigned SpmWaysWidth = 6;

  // Bit 0 of the op requests write-back of dirty lines.
  function automatic logic insn_has_flush(input insn_e op);
    return op[0];
  endfunction

  // Bit 1 of the op requests clearing the valid bit.
  function automatic logic insn_has_inv(input insn_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/spatz_l1d_line_walker.sv
// Set/way walk counter. Ways run 0..eff_ways-1 inside each set, sets run
// 0..NumSets-1; last_o flags the final line of the walk.
module spatz_l1d_line_walker
  import spatz_l1d_pkg::*;
#(
  parameter int unsigned NumSets  = 64,
  parameter int unsigned NumWays  = 4,
  parameter int unsigned SetWidth = $clog2(NumSets),
  parameter int unsigned WayWidth = $clog2(NumWays)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic                step_i,
  input  logic [WayWidth:0]   eff_ways_i,
  output logic [SetWidth-1:0] set_o,
  output logic [WayWidth-1:0] way_o,
  output logic                last_o
);

  localparam logic [WayWidth:0]   WayOne  = (WayWidth+1)'(1);
  localparam logic [SetWidth-1:0] SetOne  = SetWidth'(1);
  localparam logic [SetWidth-1:0] SetLast = SetWidth'(NumSets - 1);

  logic [SetWidth-1:0] r_set;
  logic [WayWidth-1:0] r_way;
  logic [WayWidth:0]   w_way_inc;
  logic                w_last_way;

  // The way count is one bit wider so a full set of ways (e.g. 32) compares cleanly.
  assign w_way_inc  = {1'b0, r_way} + WayOne;
  assign w_last_way = (w_way_inc == eff_ways_i);
  assign last_o     = w_last_way && (r_set == SetLast);
  assign set_o      = r_set;
  assign way_o      = r_way;

  // Advance way, wrapping into the next set after the last enabled way.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_set <= '0;
      r_way <= '0;
    end else if (step_i) begin
      if (w_last_way) begin
        r_way <= '0;
        r_set <= r_set + SetOne;
      end else begin
        r_way <= w_way_inc[WayWidth-1:0];
      end
    end
  end

endmodule

// File: rtl/spatz_l1d_maint_ctrl.sv
// Spatz L1D maintenance controller: walks every non-scratchpad line and
// flushes and/or invalidates it through the tag and write-back ports.
// Optional feature macro: SPATZ_L1D_MAINT_PERF_EN (write-back line counter).
module spatz_l1d_maint_ctrl
  import spatz_l1d_pkg::*;
#(
  parameter int unsigned NumSets  = 64,
  parameter int unsigned NumWays  = 4,
  parameter int unsigned SetWidth = $clog2(NumSets),
  parameter int unsigned WayWidth = $clog2(NumWays)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [1:0]              insn_i,
  input  logic                    insn_valid_i,
  output logic                    insn_ready_o,
  input  logic [SpmWaysWidth-1:0] spm_ways_i,
  output logic                    busy_o,
  output logic                    tag_req_valid_o,
  input  logic                    tag_req_ready_i,
  output logic                    tag_req_we_o,
  output logic [SetWidth-1:0]     tag_req_set_o,
  output logic [WayWidth-1:0]     tag_req_way_o,
  input  logic                    tag_rsp_valid_i,
  input  logic                    tag_rsp_vld_i,
  input  logic                    tag_rsp_dirty_i,
  output logic                    wb_req_valid_o,
  input  logic                    wb_req_ready_i,
  input  logic                    wb_done_i,
  output logic [31:0]             lines_wb_o,
  output state_e                  dbg_state_o
);

  // Handshakes: a request transfers on the rising edge where valid and ready
  // are both high. Valid is a pure function of the FSM state, so it is never
  // dropped before that edge, and set/way/we come from registers that only
  // move in ST_NEXT, so the payload is stable while valid is high. Only one
  // state issues a request at a time, so at most one is outstanding.

  localparam logic [SpmWaysWidth-1:0] NumWaysW = SpmWaysWidth'(NumWays);

  state_e              r_state;
  state_e              w_state_next;
  insn_e               r_op;
  logic [WayWidth:0]   r_eff_ways;
  logic [WayWidth:0]   w_eff_ways_in;
  logic                r_ready;
  logic                w_accept;
  logic                w_step;
  logic                w_last;
  logic                w_run;
  logic [SetWidth-1:0] w_set;
  logic [WayWidth-1:0] w_way;
  logic [31:0]         w_lines_wb;

  // Ways left for the walk once the scratchpad ways are carved off the top.
  assign w_eff_ways_in = (spm_ways_i >= NumWaysW) ? '0
                       : (WayWidth+1)'(NumWaysW - spm_ways_i);

  assign w_accept = (r_state == ST_IDLE) && insn_valid_i;
  assign w_step   = (r_state == ST_NEXT);

  spatz_l1d_line_walker #(
    .NumSets (NumSets),
    .NumWays (NumWays)
  ) i_walker (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (w_accept),
    .step_i     (w_step),
    .eff_ways_i (r_eff_ways),
    .set_o      (w_set),
    .way_o      (w_way),
    .last_o     (w_last)
  );

  // State register, latched op and the registered completion pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_op       <= INSN_NOP;
      r_eff_ways <= '0;
      r_ready    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ready <= (r_state == ST_DONE);
      if (w_accept) begin
        r_op       <= insn_e'(insn_i);
        r_eff_ways <= w_eff_ways_in;
      end
    end
  end

  // Next-state logic of the line walk.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (insn_valid_i) begin
          if ((insn_e'(insn_i) == INSN_NOP) || (w_eff_ways_in == '0)) begin
            w_state_next = ST_DONE;
          end else begin
            w_state_next = ST_RD_TAG;
          end
        end
      end
      ST_RD_TAG: begin
        if (tag_req_ready_i) w_state_next = ST_WAIT_TAG;
      end
      ST_WAIT_TAG: begin
        if (tag_rsp_valid_i) begin
          if (insn_has_flush(r_op) && tag_rsp_vld_i && tag_rsp_dirty_i) begin
            w_state_next = ST_WB_REQ;
          end else if (insn_has_inv(r_op)) begin
            w_state_next = ST_WR_TAG;
          end else begin
            w_state_next = ST_NEXT;
          end
        end
      end
      ST_WB_REQ: begin
        if (wb_req_ready_i) w_state_next = ST_WB_WAIT;
      end
      ST_WB_WAIT: begin
        // Only flush ops reach here; the written-back line is always cleaned.
        if (wb_done_i) w_state_next = ST_WR_TAG;
      end
      ST_WR_TAG: begin
        if (tag_req_ready_i) w_state_next = ST_NEXT;
      end
      ST_NEXT: begin
        w_state_next = w_last ? ST_DONE : ST_RD_TAG;
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

`ifdef SPATZ_L1D_MAINT_PERF_EN
  logic [31:0] r_lines_wb;

  // Count completed write-backs; wraps naturally at 2^32.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lines_wb <= '0;
    end else if ((r_state == ST_WB_WAIT) && wb_done_i) begin
      r_lines_wb <= r_lines_wb + 32'd1;
    end
  end

  assign w_lines_wb = r_lines_wb;
`else
  assign w_lines_wb = '0;
`endif

  // Outputs are forced low while reset is asserted, even before the first edge.
  assign w_run           = !rst_i;
  assign busy_o          = w_run && (r_state != ST_IDLE);
  assign insn_ready_o    = w_run && r_ready;
  assign tag_req_valid_o = w_run && ((r_state == ST_RD_TAG) || (r_state == ST_WR_TAG));
  assign tag_req_we_o    = w_run && (r_state == ST_WR_TAG);
  assign tag_req_set_o   = w_run ? w_set : '0;
  assign tag_req_way_o   = w_run ? w_way : '0;
  assign wb_req_valid_o  = w_run && (r_state == ST_WB_REQ);
  assign lines_wb_o      = w_run ? w_lines_wb : '0;
  assign dbg_state_o     = w_run ? r_state : ST_IDLE;

endmodule

// File: tb/tb_spatz_l1d_maint_ctrl.sv
// Bench for spatz_l1d_maint_ctrl (NumSets=4, NumWays=4). A tag memory and
// write-back engine model respond with random latency and random ready;
// every handshake is logged and compared with a line-walk reference.
module tb_spatz_l1d_maint_ctrl;
  import spatz_l1d_pkg::*;

  localparam int NS = 4;
  localparam int NW = 4;
  localparam int SW = 2;
  localparam int WW = 2;
  localparam int EW = 2 + SW + WW;
  localparam logic [1:0] K_RD = 2'd1;
  localparam logic [1:0] K_WR = 2'd2;
  localparam logic [1:0] K_WB = 2'd3;
`ifdef SPATZ_L1D_MAINT_PERF_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic          clk;
  logic          rst_i;
  logic [1:0]    insn_i;
  logic          insn_valid_i;
  logic          insn_ready_o;
  logic [5:0]    spm_ways_i;
  logic          busy_o;
  logic          tag_req_valid_o;
  logic          tag_req_ready_i;
  logic          tag_req_we_o;
  logic [SW-1:0] tag_req_set_o;
  logic [WW-1:0] tag_req_way_o;
  logic          tag_rsp_valid_i;
  logic          tag_rsp_vld_i;
  logic          tag_rsp_dirty_i;
  logic          wb_req_valid_o;
  logic          wb_req_ready_i;
  logic          wb_done_i;
  logic [31:0]   lines_wb_o;
  state_e        dbg_state_o;

  int checks;
  int failures;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs_q[$];

  bit mem_vld [NS][NW];
  bit mem_dirty [NS][NW];

  int rsp_cnt, rsp_set, rsp_way, wb_cnt;
  bit bp_hold, hold_wb;
  int ready_cnt, tag_valid_cycles, wb_hs_cnt;
  int total_wb;
  int cur_r0, cur_nwb;

  bit            p_tvalid, p_tready, p_twe, p_wvalid, p_wready, p_ready;
  logic [SW-1:0] p_set;
  logic [WW-1:0] p_way;

  spatz_l1d_maint_ctrl #(
    .NumSets (NS),
    .NumWays (NW)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .insn_i          (insn_i),
    .insn_valid_i    (insn_valid_i),
    .insn_ready_o    (insn_ready_o),
    .spm_ways_i      (spm_ways_i),
    .busy_o          (busy_o),
    .tag_req_valid_o (tag_req_valid_o),
    .tag_req_ready_i (tag_req_ready_i),
    .tag_req_we_o    (tag_req_we_o),
    .tag_req_set_o   (tag_req_set_o),
    .tag_req_way_o   (tag_req_way_o),
    .tag_rsp_valid_i (tag_rsp_valid_i),
    .tag_rsp_vld_i   (tag_rsp_vld_i),
    .tag_rsp_dirty_i (tag_rsp_dirty_i),
    .wb_req_valid_o  (wb_req_valid_o),
    .wb_req_ready_i  (wb_req_ready_i),
    .wb_done_i       (wb_done_i),
    .lines_wb_o      (lines_wb_o),
    .dbg_state_o     (dbg_state_o)
  );

  // Clock and reset defaults
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Responder and monitor: inputs driven on the falling edge, outputs
  // sampled 1 ns later; a transfer seen here completes on the next rising edge.
  initial begin
    tag_req_ready_i = 0; tag_rsp_valid_i = 0; tag_rsp_vld_i = 0;
    tag_rsp_dirty_i = 0; wb_req_ready_i = 0; wb_done_i = 0;
    p_tvalid = 0; p_tready = 0; p_twe = 0; p_wvalid = 0; p_wready = 0; p_ready = 0;
    p_set = '0; p_way = '0;
    forever begin
      @(negedge clk);
      tag_rsp_valid_i = 1'b0;
      wb_done_i       = 1'b0;
      tag_req_ready_i = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
      wb_req_ready_i  = ($urandom_range(0, 2) != 0);
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          tag_rsp_valid_i = 1'b1;
          tag_rsp_vld_i   = mem_vld[rsp_set][rsp_way];
          tag_rsp_dirty_i = mem_dirty[rsp_set][rsp_way];
        end
      end
      if (wb_cnt > 0 && !hold_wb) begin
        wb_cnt--;
        if (wb_cnt == 0) wb_done_i = 1'b1;
      end
      #1;
      if (!rst_i) begin
        if (tag_req_valid_o) begin
          tag_valid_cycles++;
          checks++;
          if (rsp_cnt > 0 || wb_cnt > 0 || wb_req_valid_o) begin
            failures++;
            $display("FAIL outstanding: tag request while rsp_cnt=%0d wb_cnt=%0d wb_valid=%0b", rsp_cnt, wb_cnt, wb_req_valid_o);
          end
        end
        if (p_tvalid && !p_tready) begin
          checks++;
          if (!(tag_req_valid_o === 1'b1 && tag_req_we_o === p_twe &&
                tag_req_set_o === p_set && tag_req_way_o === p_way)) begin
            failures++;
            $display("FAIL tag_stable: got v=%0b we=%0b s=%0d w=%0d, required v=1 we=%0b s=%0d w=%0d",
                     tag_req_valid_o, tag_req_we_o, tag_req_set_o, tag_req_way_o, p_twe, p_set, p_way);
          end
        end
        if (p_wvalid && !p_wready) begin
          checks++;
          if (!(wb_req_valid_o === 1'b1 && tag_req_set_o === p_set && tag_req_way_o === p_way)) begin
            failures++;
            $display("FAIL wb_stable: got v=%0b s=%0d w=%0d, required v=1 s=%0d w=%0d",
                     wb_req_valid_o, tag_req_set_o, tag_req_way_o, p_set, p_way);
          end
        end
        if (tag_req_valid_o && tag_req_ready_i) begin
          if (tag_req_we_o) begin
            obs_q.push_back({K_WR, tag_req_set_o, tag_req_way_o});
            mem_vld[tag_req_set_o][tag_req_way_o]   = 1'b0;
            mem_dirty[tag_req_set_o][tag_req_way_o] = 1'b0;
          end else begin
            obs_q.push_back({K_RD, tag_req_set_o, tag_req_way_o});
            rsp_cnt = $urandom_range(1, 3);
            rsp_set = int'(tag_req_set_o);
            rsp_way = int'(tag_req_way_o);
          end
        end
        if (wb_req_valid_o && wb_req_ready_i) begin
          obs_q.push_back({K_WB, tag_req_set_o, tag_req_way_o});
          wb_cnt = $urandom_range(1, 4);
          wb_hs_cnt++;
        end
        if (insn_ready_o) begin
          ready_cnt++;
          checks++;
          if (p_ready) begin
            failures++;
            $display("FAIL ready_width: insn_ready_o high 2 cycles in a row, required 1");
          end
        end
        p_tvalid = tag_req_valid_o; p_tready = tag_req_ready_i; p_twe = tag_req_we_o;
        p_wvalid = wb_req_valid_o;  p_wready = wb_req_ready_i;  p_ready = insn_ready_o;
        p_set = tag_req_set_o; p_way = tag_req_way_o;
      end else begin
        p_tvalid = 0; p_tready = 0; p_wvalid = 0; p_wready = 0; p_ready = 0;
      end
    end
  end

  // Reference: expected handshake sequence of one op from the memory contents.
  task automatic build_expected(input logic [1:0] op, input int spm, output int n_wb);
    int eff;
    eff  = (spm >= NW) ? 0 : NW - spm;
    n_wb = 0;
    exp_q.delete();
    if (op == 2'b00) return;
    for (int s = 0; s < NS; s++) begin
      for (int w = 0; w < eff; w++) begin
        exp_q.push_back({K_RD, SW'(s), WW'(w)});
        if (op[0] && mem_vld[s][w] && mem_dirty[s][w]) begin
          exp_q.push_back({K_WB, SW'(s), WW'(w)});
          exp_q.push_back({K_WR, SW'(s), WW'(w)});
          n_wb++;
        end else if (op[1]) begin
          exp_q.push_back({K_WR, SW'(s), WW'(w)});
        end
      end
    end
  endtask

  task automatic randomize_mem();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) begin
        mem_vld[s][w]   = ($urandom_range(0, 1) == 1);
        mem_dirty[s][w] = ($urandom_range(0, 1) == 1);
      end
  endtask

  // Driver: build the expectation, then pulse the op for one cycle.
  task automatic start_op(input logic [1:0] op, input int spm);
    build_expected(op, spm, cur_nwb);
    obs_q.delete();
    cur_r0 = ready_cnt;
    @(negedge clk);
    insn_i       = op;
    spm_ways_i   = 6'(spm);
    insn_valid_i = 1'b1;
    @(negedge clk);
    insn_valid_i = 1'b0;
  endtask

  // Wait for completion and score the op; optionally fire an ignored op mid-walk.
  task automatic finish_op(input string name, input logic [1:0] op, input bit spurious);
    int cyc;
    cyc = 0;
    while (ready_cnt == cur_r0 && cyc < 3000) begin
      if (spurious && cyc == 2) begin
        insn_i = ~op; spm_ways_i = 6'd0; insn_valid_i = 1'b1;
      end else begin
        insn_valid_i = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    insn_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    total_wb += cur_nwb;
    checks++;
    if (ready_cnt - cur_r0 != 1) begin
      failures++;
      $display("FAIL %s ready_pulses: got %0d required 1 (cycles waited %0d)", name, ready_cnt - cur_r0, cyc);
    end
    checks++;
    if (busy_o !== 1'b0) begin
      failures++;
      $display("FAIL %s busy_after: got %0b required 0", name, busy_o);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s seq_len: got %0d required %0d", name, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL %s seq[%0d]: got kind=%0d s=%0d w=%0d required kind=%0d s=%0d w=%0d", name, i,
                 obs_q[i][EW-1 -: 2], obs_q[i][SW+WW-1 -: SW], obs_q[i][WW-1:0],
                 exp_q[i][EW-1 -: 2], exp_q[i][SW+WW-1 -: SW], exp_q[i][WW-1:0]);
      end
    end
    checks++;
    if (lines_wb_o !== (PerfEn ? 32'(total_wb) : 32'd0)) begin
      failures++;
      $display("FAIL %s lines_wb: got %0d required %0d", name, lines_wb_o, PerfEn ? total_wb : 0);
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input int spm, input bit spurious);
    start_op(op, spm);
    finish_op(name, op, spurious);
  endtask

  task automatic test_reset();
    rst_i = 1'b1; insn_i = 2'b11; insn_valid_i = 1'b0; spm_ways_i = 6'd0;
    bp_hold = 0; hold_wb = 0; rsp_cnt = 0; wb_cnt = 0; total_wb = 0;
    repeat (2) @(negedge clk);
    insn_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({busy_o, insn_ready_o, tag_req_valid_o, tag_req_we_o, wb_req_valid_o} !== 5'b0 ||
          lines_wb_o !== 32'd0 || tag_req_set_o !== '0 || tag_req_way_o !== '0) begin
        failures++;
        $display("FAIL reset_outputs: busy=%0b rdy=%0b tv=%0b we=%0b wv=%0b lines=%0d, required all 0",
                 busy_o, insn_ready_o, tag_req_valid_o, tag_req_we_o, wb_req_valid_o, lines_wb_o);
      end
    end
    insn_valid_i = 1'b0;
    rst_i = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || dbg_state_o !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_idle: busy=%0b state=%0d, required busy=0 state=IDLE", busy_o, dbg_state_o);
    end
  endtask

  task automatic test_noop();
    int tv0, r0;
    tv0 = tag_valid_cycles;
    r0  = ready_cnt;
    obs_q.delete();
    @(negedge clk);
    insn_i = 2'b00; spm_ways_i = 6'd0; insn_valid_i = 1'b1;
    @(negedge clk);
    insn_valid_i = 1'b0;
    checks++;
    if (insn_ready_o !== 1'b0 || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL noop_cycle1: rdy=%0b busy=%0b, required rdy=0 busy=1", insn_ready_o, busy_o);
    end
    @(negedge clk);
    checks++;
    if (insn_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL noop_cycle2: rdy=%0b, required 1", insn_ready_o);
    end
    @(negedge clk);
    checks++;
    if (insn_ready_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL noop_cycle3: rdy=%0b busy=%0b, required 0 0", insn_ready_o, busy_o);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (tag_valid_cycles != tv0 || obs_q.size() != 0 || ready_cnt - r0 != 1) begin
      failures++;
      $display("FAIL noop_requests: tag_valid_cycles=%0d handshakes=%0d ready=%0d, required 0 0 1",
               tag_valid_cycles - tv0, obs_q.size(), ready_cnt - r0);
    end
  endtask

  task automatic test_invalidate();
    randomize_mem();
    run_op("inv_2way", 2'b10, 2, 1'b0);
    randomize_mem();
    run_op("inv_4way", 2'b10, 0, 1'b1);
  endtask

  task automatic test_flush();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) begin
        mem_vld[s][w] = 1'b1; mem_dirty[s][w] = 1'b0;
      end
    mem_dirty[2][1] = 1'b1;
    run_op("flush_one", 2'b01, 0, 1'b0);
    checks++;
    if (mem_dirty[2][1] !== 1'b0 || mem_vld[2][1] !== 1'b0) begin
      failures++;
      $display("FAIL flush_cleaned: line(2,1) vld=%0b dirty=%0b, required 0 0", mem_vld[2][1], mem_dirty[2][1]);
    end
  endtask

  task automatic test_spm_skip();
    randomize_mem();
    run_op("spm3_finv", 2'b11, 3, 1'b1);
    randomize_mem();
    run_op("spm4_flush", 2'b01, 4, 1'b0);
    run_op("spm37_inv", 2'b10, 37, 1'b0);
  endtask

  task automatic test_backpressure();
    int n00;
    randomize_mem();
    bp_hold = 1'b1;
    start_op(2'b10, 3);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (tag_req_valid_o !== 1'b1 || tag_req_we_o !== 1'b0 ||
          tag_req_set_o !== 2'd0 || tag_req_way_o !== 2'd0) begin
        failures++;
        $display("FAIL bp_hold[%0d]: v=%0b we=%0b s=%0d w=%0d, required v=1 we=0 s=0 w=0",
                 i, tag_req_valid_o, tag_req_we_o, tag_req_set_o, tag_req_way_o);
      end
      @(negedge clk);
    end
    bp_hold = 1'b0;
    finish_op("backpressure", 2'b10, 1'b0);
    n00 = 0;
    foreach (obs_q[i]) if (obs_q[i] == {K_RD, 2'd0, 2'd0}) n00++;
    checks++;
    if (n00 != 1) begin
      failures++;
      $display("FAIL bp_once: read(0,0) accepted %0d times, required 1", n00);
    end
  endtask

  task automatic test_reset_mid();
    int r0, cyc, n_obs;
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) begin
        mem_vld[s][w] = 1'b1; mem_dirty[s][w] = 1'b1;
      end
    hold_wb = 1'b1;
    start_op(2'b01, 0);
    r0 = cur_r0;
    cyc = 0;
    while (wb_hs_cnt == 0 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (wb_hs_cnt == 0) begin
      failures++;
      $display("FAIL rstmid_wb_wait: no write-back request after %0d cycles, required one", cyc);
    end
    @(negedge clk);
    rst_i = 1'b1;
    hold_wb = 1'b0; wb_cnt = 0; rsp_cnt = 0;
    @(negedge clk);
    rst_i = 1'b0;
    total_wb = 0;
    n_obs = obs_q.size();
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || tag_req_valid_o !== 1'b0 || wb_req_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_idle: busy=%0b tv=%0b wv=%0b, required 0 0 0", busy_o, tag_req_valid_o, wb_req_valid_o);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (ready_cnt != r0 || obs_q.size() != n_obs) begin
      failures++;
      $display("FAIL rstmid_quiet: ready=%0d new_handshakes=%0d, required 0 0", ready_cnt - r0, obs_q.size() - n_obs);
    end
    run_op("after_rst", 2'b10, 3, 1'b0);
  endtask

  task automatic test_random();
    logic [1:0] op;
    int spm;
    for (int k = 0; k < 6; k++) begin
      randomize_mem();
      op  = 2'($urandom_range(1, 3));
      spm = $urandom_range(0, 4);
      run_op("random", op, spm, spm < NW);
    end
  endtask

  // Test sequence and final report
  initial begin
    checks = 0; failures = 0;
    ready_cnt = 0; tag_valid_cycles = 0; wb_hs_cnt = 0;
    rst_i = 1'b1; insn_valid_i = 1'b0; insn_i = 2'b00; spm_ways_i = 6'd0;
    bp_hold = 0; hold_wb = 0; rsp_cnt = 0; wb_cnt = 0; total_wb = 0;
    test_reset();
    test_noop();
    test_invalidate();
    test_flush();
    test_spm_skip();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
